mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
MEM stage of the 5-stage MIPS pipeline, directly downstream of the EX/MEM buffer; consumes its outputs unchanged. Contains the word-addressed data memory with a configurable wait-state access FSM, which stalls upstream stages during multi-cycle loads and stores. Resolves the branch decision and registers the MEM/WB pipeline outputs for writeback.

Parameters:
MEM_WORDS, 256, data memory depth in 32-bit words; power of two.
WAIT_STATES, 2, extra cycles per load/store; legal range 0..7.

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset
RegWrite_in  in  1  WB control from EX/MEM
MemToReg_in  in  1  WB control from EX/MEM
MemRead_in  in  1  load request
MemWrite_in  in  1  store request
Branch_in  in  1  branch instruction flag
Zero_in  in  1  ALU zero flag
ALU_Result_in  in  32  byte address for memory accesses, or ALU result
StoreData_in  in  32  store data
WriteReg_in  in  5  destination register
PCSrc  out  1  take branch; combinational
stall  out  1  hold PC, IF/ID, ID/EX and EX/MEM; combinational
RegWrite_out  out  1  registered MEM/WB control
MemToReg_out  out  1  registered MEM/WB control
ReadData_out  out  32  registered load data
ALU_Result_out  out  32  registered ALU result
WriteReg_out  out  5  registered destination register
misaligned_err  out  1  registered one-cycle pulse

Behaviour:
- Reset (reset==0 at a posedge):
  - All registered outputs go to 0; FSM goes to IDLE; wait counter goes to 0.
  - Memory contents are preserved.
  - While reset==0, stall and PCSrc are forced to 0.
  - Reset during WAIT aborts the access; no write occurs.
- PCSrc = Branch_in & Zero_in, combinational, independent of stall.
- access = MemRead_in | MemWrite_in. Word index = ALU_Result_in[log2(MEM_WORDS)+1:2]; higher address bits are ignored (address wraps).
- FSM states: IDLE, WAIT. Counter width is 3 bits.
  - IDLE, with access and WAIT_STATES>0: stall=1; cnt<=WAIT_STATES-1; go to WAIT.
  - IDLE, with access and WAIT_STATES==0: stall=0; the access completes at this edge.
  - IDLE, no access: stall=0; the instruction passes through.
  - WAIT, cnt!=0: stall=1; cnt<=cnt-1.
  - WAIT, cnt==0: stall=0; the access completes at this edge; go to IDLE.
- An access takes WAIT_STATES+1 cycles, with stall high for the first WAIT_STATES of them. Upstream must hold all inputs stable while stall=1.
- Completing edge (stall==0 and access):
  - Store: mem[idx]<=StoreData_in, written exactly once per instruction.
  - Load: ReadData_out<=mem[idx], read combinationally from the array.
  - MemRead and MemWrite both set: the store wins and ReadData_out<=0.
  - Misaligned (ALU_Result_in[1:0]!=0): the store is suppressed; a load returns the aligned word. misaligned_err<=1 for that cycle only; otherwise it is 0 on every other edge.
- MEM/WB register, on any edge with stall==0: capture RegWrite_in, MemToReg_in, ALU_Result_in and WriteReg_in. ReadData_out<=0 when there is no load.
- Stall edge: insert a bubble. RegWrite_out<=0 and MemToReg_out<=0; the data outputs hold their values.
- Latency: non-memory instructions reach the outputs 1 cycle after presentation. Loads/stores reach the outputs WAIT_STATES+1 cycles after presentation.

Decomposition:
- Shared package mips_pkg: FSM state encoding (IDLE=0, WAIT=1), WAIT_CNT_W=3, and the word-offset constant (2).
- One sub-module: data_mem.
  - MEM_WORDS-deep 32-bit array.
  - Synchronous write with write enable.
  - Asynchronous read.
  - No reset.
- mem_stage holds the FSM, branch logic and MEM/WB registers.

Test Plan:
1. Hold reset=0 for 2 cycles, with random inputs -> all outputs 0, stall=0, PCSrc=0. Release -> FSM in IDLE.
2. SW: MemWrite=1, ALU_Result=0x10, StoreData=0xDEADBEEF, held while stalled -> stall=1 for exactly 2 cycles, then 0. mem[4]==0xDEADBEEF with a single write strobe. RegWrite_out stays 0.
3. LW: MemRead=1, RegWrite=1, MemToReg=1, ALU_Result=0x10, WriteReg=8 -> bubbles for 2 cycles. After the completing edge: ReadData_out=0xDEADBEEF, RegWrite_out=1, MemToReg_out=1, WriteReg_out=8.
4. R-type then branch:
   - ALU_Result=0x1234, RegWrite=1, WriteReg=3 -> ALU_Result_out=0x1234 and WriteReg_out=3 after 1 cycle; stall never high.
   - Branch=1, Zero=1 -> PCSrc=1 in the same cycle. Zero=0 -> PCSrc=0.
5. SW to 0x13, data 0x55 -> misaligned_err=1 for one cycle after completion; mem[4] still 0xDEADBEEF.
6. SW to 0x20, data 0xA5A5A5A5; drive reset=0 during the first WAIT cycle -> mem[8] unchanged, stall=0, FSM in IDLE. After release, repeating the SW completes normally.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS MEM stage: access FSM encoding and
// address/counter geometry.
package mips_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

    localparam int WAIT_CNT_W = 3;
    localparam int WORD_OFS   = 2;

endpackage

// File: rtl/data_mem.sv
// Word-addressed data memory: synchronous write, asynchronous read, no reset.
module data_mem #(
    parameter int MEM_WORDS = 256,
    parameter int AW        = $clog2(MEM_WORDS)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [MEM_WORDS];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: wait-state data memory access FSM, branch decision and
// MEM/WB pipeline register.
module mem_stage
    import mips_pkg::*;
#(
    parameter int MEM_WORDS   = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWrite_in,
    input  logic        MemToReg_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic        Branch_in,
    input  logic        Zero_in,
    input  logic [31:0] ALU_Result_in,
    input  logic [31:0] StoreData_in,
    input  logic [4:0]  WriteReg_in,
    output logic        PCSrc,
    output logic        stall,
    output logic        RegWrite_out,
    output logic        MemToReg_out,
    output logic [31:0] ReadData_out,
    output logic [31:0] ALU_Result_out,
    output logic [4:0]  WriteReg_out,
    output logic        misaligned_err
);

    localparam int AW = $clog2(MEM_WORDS);

    mem_state_e            state_q, state_d;
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

    logic          access;
    logic          misaligned;
    logic          complete;
    logic          mem_we;
    logic [AW-1:0] word_idx;
    logic [31:0]   rdata;
    logic [31:0]   rd_d;
    logic          unused_addr_hi;

    logic        rw_q, mtr_q, mis_q;
    logic [31:0] rd_q, alu_q;
    logic [4:0]  wr_q;

    assign access         = MemRead_in | MemWrite_in;
    assign misaligned     = (ALU_Result_in[1:0] != 2'b00);
    assign word_idx       = ALU_Result_in[AW+WORD_OFS-1:WORD_OFS];
    assign unused_addr_hi = ^ALU_Result_in[31:AW+WORD_OFS];

    // Branch resolution is held off only by reset, never by a memory stall.
    assign PCSrc = reset & Branch_in & Zero_in;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        if (reset) begin
            case (state_q)
                IDLE: begin
                    if (access && (WAIT_STATES > 0)) begin
                        stall   = 1'b1;
                        cnt_d   = WAIT_CNT_W'(WAIT_STATES - 1);
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q != '0) begin
                        stall = 1'b1;
                        cnt_d = cnt_q - WAIT_CNT_W'(1);
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // A store that collides with a load wins; misaligned stores are dropped.
    assign complete = reset & ~stall & access;
    assign mem_we   = complete & MemWrite_in & ~misaligned;
    assign rd_d     = (complete && MemRead_in && !MemWrite_in) ? rdata : '0;

    data_mem #(
        .MEM_WORDS (MEM_WORDS),
        .AW        (AW)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .addr_i  (word_idx),
        .wdata_i (StoreData_in),
        .rdata_o (rdata)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rw_q    <= 1'b0;
            mtr_q   <= 1'b0;
            mis_q   <= 1'b0;
            rd_q    <= '0;
            alu_q   <= '0;
            wr_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (stall) begin
                // Bubble: kill writeback control, keep the data fields.
                rw_q  <= 1'b0;
                mtr_q <= 1'b0;
                mis_q <= 1'b0;
            end else begin
                rw_q  <= RegWrite_in;
                mtr_q <= MemToReg_in;
                mis_q <= complete & misaligned;
                rd_q  <= rd_d;
                alu_q <= ALU_Result_in;
                wr_q  <= WriteReg_in;
            end
        end
    end

    assign RegWrite_out   = rw_q;
    assign MemToReg_out   = mtr_q;
    assign misaligned_err = mis_q;
    assign ReadData_out   = rd_q;
    assign ALU_Result_out = alu_q;
    assign WriteReg_out   = wr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage against a cycle-count model.
module tb_mem_stage;

    localparam int MEM_WORDS   = 256;
    localparam int WAIT_STATES = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWrite_in, MemToReg_in, MemRead_in, MemWrite_in;
    logic        Branch_in, Zero_in;
    logic [31:0] ALU_Result_in, StoreData_in;
    logic [4:0]  WriteReg_in;
    logic        PCSrc, stall, RegWrite_out, MemToReg_out, misaligned_err;
    logic [31:0] ReadData_out, ALU_Result_out;
    logic [4:0]  WriteReg_out;

    mem_stage #(.MEM_WORDS(MEM_WORDS), .WAIT_STATES(WAIT_STATES)) dut (
        .clk(clk), .reset(reset),
        .RegWrite_in(RegWrite_in), .MemToReg_in(MemToReg_in),
        .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
        .Branch_in(Branch_in), .Zero_in(Zero_in),
        .ALU_Result_in(ALU_Result_in), .StoreData_in(StoreData_in),
        .WriteReg_in(WriteReg_in),
        .PCSrc(PCSrc), .stall(stall),
        .RegWrite_out(RegWrite_out), .MemToReg_out(MemToReg_out),
        .ReadData_out(ReadData_out), .ALU_Result_out(ALU_Result_out),
        .WriteReg_out(WriteReg_out), .misaligned_err(misaligned_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    // Reference state
    logic [31:0] mdl_mem [MEM_WORDS];
    logic        exp_stall, exp_pcsrc, exp_rw, exp_mtr, exp_mis;
    logic [31:0] exp_rd, exp_alu;
    logic [4:0]  exp_wr;
    int          exp_strobes = 0;
    int          strobe_cnt  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (dut.mem_we === 1'b1) strobe_cnt++;
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("stall",    {31'd0, stall},          {31'd0, exp_stall});
            chk("PCSrc",    {31'd0, PCSrc},          {31'd0, exp_pcsrc});
            chk("RegWrite", {31'd0, RegWrite_out},   {31'd0, exp_rw});
            chk("MemToReg", {31'd0, MemToReg_out},   {31'd0, exp_mtr});
            chk("misalign", {31'd0, misaligned_err}, {31'd0, exp_mis});
            chk("ReadData", ReadData_out,            exp_rd);
            chk("ALU_out",  ALU_Result_out,          exp_alu);
            chk("WriteReg", {27'd0, WriteReg_out},   {27'd0, exp_wr});
            chk("strobes",  strobe_cnt,              exp_strobes);
        end
    end

    task automatic rand_inputs();
        RegWrite_in   = 1'($urandom);
        MemToReg_in   = 1'($urandom);
        MemRead_in    = 1'($urandom);
        MemWrite_in   = 1'($urandom);
        Branch_in     = 1'($urandom);
        Zero_in       = 1'($urandom);
        ALU_Result_in = $urandom;
        StoreData_in  = $urandom;
        WriteReg_in   = 5'($urandom);
    endtask

    task automatic zero_outputs();
        exp_rw = 0; exp_mtr = 0; exp_mis = 0;
        exp_rd = '0; exp_alu = '0; exp_wr = '0;
    endtask

    // Entered and left at posedge+1.
    task automatic reset_cycles(input int n);
        reset = 1'b0;
        for (int i = 0; i < n; i++) begin
            rand_inputs();
            exp_stall = 1'b0;
            exp_pcsrc = 1'b0;
            @(posedge clk);
            zero_outputs();
            #1;
        end
        reset = 1'b1;
    endtask

    // Presents one instruction and holds it for as many cycles as the
    // access needs: WAIT_STATES stalled cycles, then a completing one.
    task automatic run_instr(input logic rw, input logic mtr, input logic mr,
                             input logic mw, input logic br, input logic z,
                             input logic [31:0] alu, input logic [31:0] sd,
                             input logic [4:0] wr);
        int n;
        int idx;
        RegWrite_in = rw; MemToReg_in = mtr; MemRead_in = mr; MemWrite_in = mw;
        Branch_in = br; Zero_in = z; ALU_Result_in = alu; StoreData_in = sd;
        WriteReg_in = wr;
        n   = (mr || mw) ? WAIT_STATES : 0;
        idx = int'((alu >> 2) % MEM_WORDS);
        for (int i = 0; i <= n; i++) begin
            exp_stall = (i < n);
            exp_pcsrc = br & z;
            @(posedge clk);
            if (i < n) begin
                exp_rw = 0; exp_mtr = 0; exp_mis = 0;
            end else begin
                exp_rw  = rw;
                exp_mtr = mtr;
                exp_alu = alu;
                exp_wr  = wr;
                exp_mis = (mr || mw) && (alu % 4 != 0);
                exp_rd  = (mr && !mw) ? mdl_mem[idx] : 32'd0;
                if (mw && (alu % 4 == 0)) begin
                    mdl_mem[idx] = sd;
                    exp_strobes++;
                end
            end
            #1;
        end
    endtask

    initial begin
        reset = 1'b0;
        rand_inputs();
        exp_stall = 0; exp_pcsrc = 0;
        zero_outputs();
        @(posedge clk); #1;
        check_en = 1'b1;

        // Reset with random inputs
        reset_cycles(2);
        chk("rst_alu_lit", ALU_Result_out, 32'd0);

        // Store, then load it back
        run_instr(0, 0, 0, 1, 0, 0, 32'h10, 32'hDEADBEEF, 5'd0);
        chk("sw_rw_lit", {31'd0, RegWrite_out}, 32'd0);
        chk("sw_strobe_lit", strobe_cnt, 1);
        run_instr(1, 1, 1, 0, 0, 0, 32'h10, 32'h0, 5'd8);
        chk("lw_data_lit", ReadData_out, 32'hDEADBEEF);
        chk("lw_wr_lit", {27'd0, WriteReg_out}, 32'd8);
        chk("lw_mtr_lit", {31'd0, MemToReg_out}, 32'd1);

        // R-type, then branch taken / not taken
        run_instr(1, 0, 0, 0, 0, 0, 32'h1234, 32'h0, 5'd3);
        chk("rtype_alu_lit", ALU_Result_out, 32'h1234);
        run_instr(0, 0, 0, 0, 1, 1, 32'h0, 32'h0, 5'd0);
        chk("pcsrc_taken_lit", {31'd0, PCSrc}, 32'd1);
        run_instr(0, 0, 0, 0, 1, 0, 32'h0, 32'h0, 5'd0);
        chk("pcsrc_nt_lit", {31'd0, PCSrc}, 32'd0);

        // Misaligned store is dropped and flagged for one cycle
        run_instr(0, 0, 0, 1, 0, 0, 32'h13, 32'h55, 5'd0);
        chk("mis_pulse_lit", {31'd0, misaligned_err}, 32'd1);
        run_instr(0, 0, 1, 0, 0, 0, 32'h10, 32'h0, 5'd9);
        chk("mis_nostore_lit", ReadData_out, 32'hDEADBEEF);
        chk("mis_clear_lit", {31'd0, misaligned_err}, 32'd0);

        // Reset during WAIT aborts the store
        run_instr(0, 0, 0, 1, 0, 0, 32'h20, 32'h11112222, 5'd0);
        RegWrite_in = 0; MemToReg_in = 0; MemRead_in = 0; MemWrite_in = 1;
        Branch_in = 0; Zero_in = 0; ALU_Result_in = 32'h20;
        StoreData_in = 32'hA5A5A5A5; WriteReg_in = 0;
        exp_stall = 1; exp_pcsrc = 0;
        @(posedge clk);
        exp_rw = 0; exp_mtr = 0; exp_mis = 0;
        #1;
        reset = 1'b0;
        exp_stall = 0;
        @(posedge clk);
        zero_outputs();
        #1;
        reset = 1'b1;
        run_instr(0, 0, 1, 0, 0, 0, 32'h20, 32'h0, 5'd1);
        chk("abort_keep_lit", ReadData_out, 32'h11112222);
        run_instr(0, 0, 0, 1, 0, 0, 32'h20, 32'hA5A5A5A5, 5'd0);
        run_instr(0, 0, 1, 0, 0, 0, 32'h20, 32'h0, 5'd1);
        chk("retry_lit", ReadData_out, 32'hA5A5A5A5);

        // Fill words 0..15 so every random load has a known value
        for (int w = 0; w < 16; w++) begin
            run_instr(0, 0, 0, 1, 0, 0, 32'(w * 4), $urandom, 5'd0);
        end

        // Random instruction stream, addresses wrapping through the high bits
        for (int k = 0; k < 300; k++) begin
            logic [31:0] a;
            a = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 15) << 2);
            if ($urandom_range(0, 5) == 0) a = a | 32'($urandom_range(1, 3));
            if ($urandom_range(0, 40) == 0) reset_cycles(1);
            run_instr(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                      1'($urandom), 1'($urandom), a, $urandom, 5'($urandom));
        end

        check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
